// File: rtl/uart_tx_arbiter_if.sv
// Wishbone register-port bundle between the arbiter (master) and the UART (slave).
// Single-beat writes only; stb mirrors cyc and we is high for every cycle.
interface uart_tx_arbiter_if;
    logic [3:0]  wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_ack_i
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter between two
// byte streams; also owns the UART baud-divider register writes.
module uart_tx_arbiter #(
    parameter logic [31:0] DEFAULT_DIV = 32'd104,
    parameter int          ACK_TIMEOUT = 65535,
    parameter int          TO_W        = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    uart_tx_arbiter_if.master wb,
    input  logic [7:0]        s0_data,
    input  logic              s0_valid,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic [7:0]        s1_data,
    input  logic              s1_valid,
    input  logic              s1_last,
    output logic              s1_ready,
    input  logic [31:0]       cfg_div,
    input  logic              cfg_div_load,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr
);
    typedef enum logic [1:0] {ST_DIV, ST_IDLE, ST_CAPTURE, ST_WRITE} state_t;

    localparam bit             TO_EN    = (ACK_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(ACK_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              cyc_reg, cyc_next;
    logic [3:0]        adr_reg, adr_next;
    logic [31:0]       dat_reg, dat_next;
    logic [3:0]        sel_reg, sel_next;
    logic [31:0]       shadow_reg, shadow_next;
    logic              pending_reg, pending_next;
    logic              winner_reg, winner_next;   // 1: s1 won the previous packet
    logic [1:0]        grant_reg, grant_next;
    logic              last_reg, last_next;
    logic [TO_W-1:0]   cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic              busy_reg, busy_next;

    logic [1:0]        req_valid;
    logic [1:0]        ready_vec;
    logic              timeout;
    logic              done;

    assign req_valid = {s1_valid, s0_valid};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == ST_CAPTURE) && grant_reg[gi] && req_valid[gi];
        end
    endgenerate

    assign s0_ready = ready_vec[0];
    assign s1_ready = ready_vec[1];

    // An ack on the limit cycle wins over the timeout.
    assign timeout = TO_EN && cyc_reg && !wb.wbm_ack_i && (cnt_reg == TO_LIMIT);
    assign done    = cyc_reg && (wb.wbm_ack_i || timeout);

    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg;
        adr_next     = adr_reg;
        dat_next     = dat_reg;
        sel_next     = sel_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        winner_next  = winner_reg;
        grant_next   = grant_reg;
        last_next    = last_reg;
        cnt_next     = (!cyc_reg || done) ? '0 : cnt_reg + TO_W'(1);
        err_next     = timeout ? 1'b1 : (err_clr ? 1'b0 : err_reg);

        case (state_reg)
            ST_DIV: begin
                if (!cyc_reg) begin
                    // First cycle out of reset: launch the default divider write.
                    cyc_next = 1'b1;
                    adr_next = 4'h0;
                    sel_next = 4'hF;
                    dat_next = shadow_reg;
                end else if (done) begin
                    cyc_next     = 1'b0;
                    pending_next = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (pending_reg) begin
                    cyc_next   = 1'b1;
                    adr_next   = 4'h0;
                    sel_next   = 4'hF;
                    dat_next   = shadow_reg;
                    state_next = ST_DIV;
                end else if (s0_valid || s1_valid) begin
                    winner_next = s1_valid && !(s0_valid && winner_reg);
                    grant_next  = winner_next ? 2'b10 : 2'b01;
                    state_next  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (|ready_vec) begin
                    last_next  = grant_reg[1] ? s1_last : s0_last;
                    dat_next   = {24'h0, grant_reg[1] ? s1_data : s0_data};
                    adr_next   = 4'h4;
                    sel_next   = 4'h1;
                    cyc_next   = 1'b1;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (done) begin
                    cyc_next = 1'b0;
                    if (last_reg) begin
                        grant_next = 2'b00;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_CAPTURE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A load always re-arms the divider write, even while one is completing.
        if (cfg_div_load) begin
            shadow_next  = cfg_div;
            pending_next = 1'b1;
        end

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_DIV;
            cyc_reg     <= 1'b0;
            adr_reg     <= 4'h0;
            dat_reg     <= 32'h0;
            sel_reg     <= 4'h0;
            shadow_reg  <= DEFAULT_DIV;
            pending_reg <= 1'b1;
            winner_reg  <= 1'b1;
            grant_reg   <= 2'b00;
            last_reg    <= 1'b0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cyc_reg     <= cyc_next;
            adr_reg     <= adr_next;
            dat_reg     <= dat_next;
            sel_reg     <= sel_next;
            shadow_reg  <= shadow_next;
            pending_reg <= pending_next;
            winner_reg  <= winner_next;
            grant_reg   <= grant_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            busy_reg    <= busy_next;
        end
    end

    assign wb.wbm_cyc_o = cyc_reg;
    assign wb.wbm_stb_o = cyc_reg;
    assign wb.wbm_we_o  = cyc_reg;
    assign wb.wbm_adr_o = adr_reg;
    assign wb.wbm_dat_o = dat_reg;
    assign wb.wbm_sel_o = sel_reg;

    assign grant       = grant_reg;
    assign busy        = busy_reg;
    assign err_timeout = err_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: drivers push expected bus writes, a monitor pops and compares on every ack.
// A second instance with a short ack timeout exercises the hung-slave path.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus ();
    uart_tx_arbiter_if bus2 ();

    logic [7:0]  s0_data = 8'h0, s1_data = 8'h0;
    logic        s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
    logic        s0_ready, s1_ready;
    logic [31:0] cfg_div = 32'h0;
    logic        cfg_div_load = 1'b0;
    logic [1:0]  grant;
    logic        busy, err_timeout;
    logic        err_clr = 1'b0;

    logic [7:0]  t_s0_data = 8'h0, t_s1_data = 8'h0;
    logic        t_s0_valid = 1'b0, t_s0_last = 1'b0, t_s1_valid = 1'b0, t_s1_last = 1'b0;
    logic        t_s0_ready, t_s1_ready;
    logic [31:0] t_cfg_div = 32'h0;
    logic        t_cfg_div_load = 1'b0;
    logic [1:0]  t_grant;
    logic        t_busy, t_err;
    logic        t_err_clr = 1'b0;

    int   ack_mode = 0;          // 0: ack at once, 1: never ack, 2: random stalls
    logic rnd_bit  = 1'b1;
    always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 2) != 0);

    assign bus.wbm_ack_i  = bus.wbm_cyc_o && bus.wbm_stb_o &&
                            ((ack_mode == 0) || ((ack_mode == 2) && rnd_bit));
    assign bus2.wbm_ack_i = 1'b0;

    uart_tx_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
        .cfg_div(cfg_div), .cfg_div_load(cfg_div_load),
        .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    uart_tx_arbiter #(.ACK_TIMEOUT(16), .TO_W(5)) dut_to (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus2),
        .s0_data(t_s0_data), .s0_valid(t_s0_valid), .s0_last(t_s0_last), .s0_ready(t_s0_ready),
        .s1_data(t_s1_data), .s1_valid(t_s1_valid), .s1_last(t_s1_last), .s1_ready(t_s1_ready),
        .cfg_div(t_cfg_div), .cfg_div_load(t_cfg_div_load),
        .grant(t_grant), .busy(t_busy), .err_timeout(t_err), .err_clr(t_err_clr)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0]  exp0[$];        // {last, byte} per requester, in issue order
    logic [8:0]  exp1[$];
    logic [31:0] exp_div[$];
    int          src_log[$];     // 1: s0 byte, 2: s1 byte, 9: divider write
    int          owner = -1;     // requester mid-packet, -1 between packets
    int          rdy0_cnt = 0, rdy1_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int log_code();
        int c = 0;
        foreach (src_log[i]) c = c * 10 + src_log[i];
        return c;
    endfunction

    // Monitor: one comparison set per completed bus write, plus stall stability.
    logic [3:0]  p_adr = 4'h0;
    logic [31:0] p_dat = 32'h0;
    logic [3:0]  p_sel = 4'h0;
    logic        p_wait = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (s0_ready) rdy0_cnt++;
            if (s1_ready) rdy1_cnt++;
            if (s0_ready || s1_ready)
                chk("ready_matches_grant", 32'({s1_ready, s0_ready}), 32'(grant));
            if (bus.wbm_cyc_o) begin
                if (p_wait)
                    chk("stall_stable", {bus.wbm_adr_o, bus.wbm_sel_o, bus.wbm_dat_o[23:0]},
                        {p_adr, p_sel, p_dat[23:0]});
                if (bus.wbm_ack_i) begin
                    p_wait = 1'b0;
                    chk("we_high", 32'(bus.wbm_we_o), 32'd1);
                    if (bus.wbm_adr_o == 4'h0) begin
                        $display("txn div dat=%0d sel=%h", bus.wbm_dat_o, bus.wbm_sel_o);
                        chk("div_sel", 32'(bus.wbm_sel_o), 32'hF);
                        chk("div_between_packets", 32'(owner), 32'hFFFF_FFFF);
                        if (exp_div.size() == 0) chk("div_unexpected", bus.wbm_dat_o, 32'hDEAD_BEEF);
                        else chk("div_dat", bus.wbm_dat_o, exp_div.pop_front());
                        src_log.push_back(9);
                    end else begin
                        int src;
                        logic [8:0] e;
                        src = int'(bus.wbm_dat_o[7]);
                        $display("txn data src=%0d dat=%h sel=%h grant=%b", src, bus.wbm_dat_o, bus.wbm_sel_o, grant);
                        chk("data_adr", 32'(bus.wbm_adr_o), 32'h4);
                        chk("data_sel", 32'(bus.wbm_sel_o), 32'h1);
                        chk("data_hi_zero", 32'(bus.wbm_dat_o[31:8]), 32'h0);
                        chk("data_grant", 32'(grant), (src == 1) ? 32'd2 : 32'd1);
                        if (owner != -1) chk("packet_atomic", 32'(src), 32'(owner));
                        if (src == 0 && exp0.size() == 0) chk("s0_unexpected", bus.wbm_dat_o, 32'h1FF);
                        else if (src == 1 && exp1.size() == 0) chk("s1_unexpected", bus.wbm_dat_o, 32'h1FF);
                        else begin
                            e = (src == 1) ? exp1.pop_front() : exp0.pop_front();
                            chk("data_byte", 32'(bus.wbm_dat_o[7:0]), 32'(e[7:0]));
                            owner = e[8] ? -1 : src;
                        end
                        src_log.push_back(src + 1);
                    end
                end else begin
                    p_wait = 1'b1;
                    p_adr  = bus.wbm_adr_o;
                    p_dat  = bus.wbm_dat_o;
                    p_sel  = bus.wbm_sel_o;
                end
            end else begin
                p_wait = 1'b0;
            end
        end
    end

    task automatic set_req(input int src, input logic v, input logic [7:0] d, input logic l);
        if (src == 0) begin s0_valid = v; s0_data = d; s0_last = l; end
        else          begin s1_valid = v; s1_data = d; s1_last = l; end
    endtask

    // Issue one packet; base < 0 means random bytes. Bit 7 tags the source.
    task automatic send_pkt(input int src, input int len, input int gap_max, input int base);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            logic       l;
            logic       got;
            int         guard;
            repeat ((gap_max > 0) ? $urandom_range(0, gap_max) : 0) @(negedge clk);
            b = (base >= 0) ? 8'(base + i) : 8'($urandom);
            b[7] = (src == 1);
            l = (i == len - 1);
            if (src == 0) exp0.push_back({l, b}); else exp1.push_back({l, b});
            set_req(src, 1'b1, b, l);
            got = 1'b0;
            guard = 0;
            while (!got && guard < 2000) begin
                #1;
                got = (src == 1) ? s1_ready : s0_ready;
                @(negedge clk);
                guard++;
            end
            if (!got) chk("req_handshake_timeout", 32'(src), 32'hFFFF);
            set_req(src, 1'b0, 8'h0, 1'b0);
        end
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            #1;
            if (!bus.wbm_cyc_o && !busy && exp0.size() == 0 && exp1.size() == 0 && exp_div.size() == 0)
                break;
        end
        chk({tag, "_drained"}, 32'(k < 5000), 32'd1);
        chk({tag, "_grant_idle"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int r0, r1, n, stall;
        exp_div.push_back(32'd104);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cyc", 32'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}), 32'd0);
        chk("rst_grant_busy_err", 32'({grant, busy, err_timeout}), 32'd0);
        chk("rst_ready", 32'({s0_ready, s1_ready}), 32'd0);
        chk("rst_to_cyc", 32'(bus2.wbm_cyc_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Timeout instance: default divider write is never acked.
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (bus2.wbm_cyc_o) n++;
            else if (n > 0) break;
        end
        chk("to_div_cycles", 32'(n), 32'd16);
        chk("to_div_err", 32'(t_err), 32'd1);
        chk("to_div_idle", 32'({t_busy, t_grant}), 32'd0);
        @(negedge clk); t_err_clr = 1'b1;
        @(negedge clk); t_err_clr = 1'b0;
        #1;
        chk("to_err_cleared", 32'(t_err), 32'd0);

        // Data write times out; err_clr collides with the timeout cycle.
        @(negedge clk);
        t_s0_valid = 1'b1; t_s0_data = 8'h55; t_s0_last = 1'b1;
        n = 0;
        for (int k = 0; k < 50 && n == 0; k++) begin
            #1;
            if (t_s0_ready) n = 1;
            @(negedge clk);
        end
        t_s0_valid = 1'b0;
        chk("to_capture", 32'(n), 32'd1);
        n = 0;
        for (int k = 0; k < 100 && n < 15; k++) begin
            #1;
            if (bus2.wbm_cyc_o) n++;
            if (n < 15) @(negedge clk);
        end
        chk("to_count_15", 32'(n), 32'd15);
        @(negedge clk); t_err_clr = 1'b1;
        #1;
        chk("to_16th_cycle", 32'({bus2.wbm_cyc_o, bus2.wbm_adr_o}), 32'h14);
        @(negedge clk); t_err_clr = 1'b0;
        #1;
        chk("to_cyc_dropped", 32'(bus2.wbm_cyc_o), 32'd0);
        chk("to_err_wins_clr", 32'(t_err), 32'd1);
        chk("to_data_idle", 32'({t_busy, t_grant}), 32'd0);

        // Main instance: reset divider write.
        drain("reset_div");
        chk("reset_div_seen", 32'(log_code()), 32'd9);

        // Both requesters valid together: s0 first (last winner after reset is s1).
        src_log.delete();
        @(negedge clk);
        fork
            send_pkt(0, 2, 0, -1);
            send_pkt(1, 2, 0, -1);
        join
        drain("rr_a");
        chk("rr_a_order", 32'(log_code()), 32'd1122);

        // Single s0 packet 0x41..0x43.
        src_log.delete();
        r0 = rdy0_cnt; r1 = rdy1_cnt;
        send_pkt(0, 3, 0, 'h41);
        drain("s0_pkt");
        chk("s0_pkt_order", 32'(log_code()), 32'd111);
        chk("s0_ready_pulses", 32'(rdy0_cnt - r0), 32'd3);
        chk("s1_ready_quiet", 32'(rdy1_cnt - r1), 32'd0);

        // Same simultaneous stimulus, s0 won last: s1 goes first.
        src_log.delete();
        fork
            send_pkt(0, 2, 0, -1);
            send_pkt(1, 2, 0, -1);
        join
        drain("rr_c");
        chk("rr_c_order", 32'(log_code()), 32'd2211);

        // s1 arrives mid-packet and must wait for s0's last byte.
        src_log.delete();
        fork
            send_pkt(0, 4, 2, -1);
            begin repeat (6) @(negedge clk); send_pkt(1, 1, 0, -1); end
        join
        drain("mid");
        chk("mid_order", 32'(log_code()), 32'd11112);

        // UART stalls 50 cycles on a data write.
        ack_mode = 1;
        r0 = rdy0_cnt;
        fork
            send_pkt(0, 2, 0, 'h10);
            begin
                n = 0;
                for (int k = 0; k < 100 && n == 0; k++) begin
                    @(negedge clk);
                    #1;
                    if (bus.wbm_cyc_o) n = 1;
                end
                r0 = rdy0_cnt;
                stall = 0;
                for (int k = 0; k < 50; k++) begin
                    if (bus.wbm_cyc_o && !bus.wbm_ack_i) stall++;
                    if (k < 49) begin @(negedge clk); #1; end
                end
                chk("hold_stall_cycles", 32'(stall), 32'd50);
                chk("hold_no_ready", 32'(rdy0_cnt - r0), 32'd0);
                @(negedge clk);
                ack_mode = 0;
            end
        join
        drain("hold");

        // Divider load during a packet is applied only after the last byte.
        src_log.delete();
        fork
            send_pkt(0, 3, 1, -1);
            begin
                repeat (2) @(negedge clk);
                cfg_div = 32'd52; cfg_div_load = 1'b1;
                exp_div.push_back(32'd52);
                @(negedge clk);
                cfg_div_load = 1'b0;
            end
        join
        drain("cfg");
        chk("cfg_after_packet", 32'(log_code()), 32'd1119);

        // Randomised traffic with random ack stalls and occasional divider loads.
        ack_mode = 2;
        fork
            for (int p = 0; p < 12; p++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                send_pkt(0, $urandom_range(1, 4), 3, -1);
            end
            for (int p = 0; p < 12; p++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                send_pkt(1, $urandom_range(1, 4), 3, -1);
            end
            for (int p = 0; p < 6; p++) begin
                repeat ($urandom_range(10, 40)) @(negedge clk);
                if (exp_div.size() == 0) begin
                    cfg_div = $urandom_range(1, 5000);
                    cfg_div_load = 1'b1;
                    exp_div.push_back(cfg_div);
                    @(negedge clk);
                    cfg_div_load = 1'b0;
                end
            end
        join
        ack_mode = 0;
        drain("random");
        chk("final_err_clear", 32'(err_timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Wishbone master that owns the UART peripheral's register port (divider at offset 0x0, data at offset 0x4) and shares its transmitter between two byte-stream requesters. Arbitration is round-robin at packet granularity, so bytes from different sources never interleave inside a packet. The block writes the baud divider after reset and on request, and drives data-register writes, holding each cycle until the UART acks. Because the UART withholds ack while its transmitter is busy, that stall provides flow control; a timeout guards against a hung slave.

Parameters:
DEFAULT_DIV, 32'd104, divider value written after reset and the reset value of the divider shadow register.
ACK_TIMEOUT, 65535, max cycles a bus cycle waits for ack; 0 disables the timeout.
TO_W, 16, width of the timeout counter; must hold ACK_TIMEOUT.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
wbm_adr_o  out  4  byte address to UART: 4'h0 divider, 4'h4 data
wbm_dat_o  out  32  write data
wbm_sel_o  out  4  byte selects
wbm_we_o  out  1  write enable; always 1 during a cycle
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe; equal to wbm_cyc_o
wbm_ack_i  in  1  UART ack; may be combinational and high in the same cycle stb rises
s0_data  in  8  requester 0 byte
s0_valid  in  1  requester 0 byte valid
s0_last  in  1  requester 0 final byte of packet
s0_ready  out  1  one-cycle pulse: s0 byte captured
s1_data, s1_valid, s1_last, s1_ready  -  same as s0 for requester 1
cfg_div  in  32  new divider value
cfg_div_load  in  1  one-cycle pulse: latch cfg_div and schedule a divider write
grant  out  2  one-hot owner of the current packet; 2'b00 when none
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky flag: an ack timeout occurred
err_clr  in  1  clears err_timeout; a new timeout in the same cycle wins

Behaviour:
- Reset (asynchronous): all outputs go to 0 immediately and bus cycle is abandoned. Divider shadow = DEFAULT_DIV, div_pending = 1, last winner = s1 (so s0 gets priority first), state = DIV.
- States: DIV, IDLE, CAPTURE, WRITE.
- DIV: cyc = stb = we = 1, adr = 4'h0, sel = 4'hF, dat = divider shadow.
  - On ack (or timeout): cyc/stb go low on the next edge, div_pending clears, next state = IDLE.
- IDLE, in priority order:
  - If div_pending, go to DIV.
  - Else if any valid, grant a requester. With both valid, grant the one that is not the last winner. Record the winner, set grant, go to CAPTURE.
  - Else stay in IDLE.
- CAPTURE: wait for the granted requester's valid.
  - When valid: assert its ready for exactly this cycle, latch data and last, go to WRITE.
  - The non-granted ready stays 0 regardless of its valid.
- WRITE: cyc = stb = we = 1, adr = 4'h4, sel = 4'h1, dat = {24'h0, byte}.
  - adr/dat/sel stay stable until ack.
  - On ack: cyc/stb drop on the next edge. If latched last = 1, clear grant and go to IDLE; else go to CAPTURE with the same grant.
- Throughput: minimum 2 cycles per byte (CAPTURE + 1 WRITE cycle). Packet switch adds one IDLE cycle.
- Packets are atomic: the grant is held until the last byte is acked. A requester that withholds last starves the other (intended).
- cfg_div_load in any state:
  - Shadow = cfg_div and div_pending = 1.
  - The write is applied in IDLE, i.e. only between packets.
  - A load arriving during DIV re-sets div_pending, so a second DIV write follows with the newest value.
- Timeout:
  - Counter clears whenever cyc = 0 and increments each cycle cyc = 1 without ack.
  - If it reaches ACK_TIMEOUT with no ack: cyc/stb drop next edge, err_timeout sets, and the transaction is treated as completed (byte dropped; last handling unchanged).
  - Ack in the same cycle the limit is reached counts as success.
- Simultaneous events:
  - ack and cfg_div_load in the same cycle: both honoured.
  - err_clr and a timeout in the same cycle: err_timeout = 1.

Test Plan:
- Release reset, ack tied to cyc -> first bus cycle: adr=0, dat=32'd104, sel=F. Then busy=0 and grant=00.
- s0 sends 0x41,0x42,0x43 (last on 0x43), UART acks immediately -> three data writes, dat=0x41/0x42/0x43, adr=4, sel=1. s0_ready pulses 3 times; grant=01 throughout, then 00.
- s0 and s1 both valid with 2-byte packets at the same cycle after reset -> s0 packet fully written, then s1. A repeat of the same stimulus serves s1 first.
- s1 asserts valid mid-way through an s0 packet -> no s1 byte appears until s0's last ack; s1_ready stays 0 meanwhile.
- UART holds ack low for 50 cycles during a data write -> cyc/stb stay high with dat stable for 50 cycles; s0_ready does not pulse again until after the ack.
- ACK_TIMEOUT=16, ack never asserted -> cyc drops after 16 cycles and err_timeout=1. err_clr clears it. cfg_div_load with 32'd52 during a packet -> divider write of 52 occurs only after the last byte's ack.
